// File: rtl/prod_accum_pkg.sv
// Shared definitions for the multiplier / accumulator datapath.
package prod_accum_pkg;

   localparam int DEF_WIDTH  = 6;
   localparam int DEF_NTERMS = 8;
   localparam int DEF_PWIDTH = 2 * DEF_WIDTH;
   localparam int DEF_AWIDTH = DEF_PWIDTH + $clog2(DEF_NTERMS);

   // Accumulator control states: summing a block, or holding a finished sum.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Sign-extend a default-width product up to the default accumulator width.
   function automatic logic [DEF_AWIDTH-1:0] sext(input logic [DEF_PWIDTH-1:0] p);
      return {{(DEF_AWIDTH - DEF_PWIDTH){p[DEF_PWIDTH-1]}}, p};
   endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / block-sum-out handshake bundle of the accumulate stage.
interface prod_accum_if #(
   parameter int WIDTH  = 6,
   parameter int NTERMS = 8
) ();

   localparam int PWIDTH = 2 * WIDTH;
   localparam int AWIDTH = PWIDTH + $clog2(NTERMS);
   localparam int CWIDTH = $clog2(NTERMS + 1);

   logic              in_valid;
   logic              in_ready;
   logic [PWIDTH-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [AWIDTH-1:0] out_sum;
   logic [CWIDTH-1:0] out_terms;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_terms
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_terms
   );

endinterface

// File: rtl/prod_accum_sext_adder.sv
// Sign-extends a product to accumulator width and adds it to a running sum.
module prod_accum_sext_adder #(
   parameter int PWIDTH = 12,
   parameter int AWIDTH = 15
) (
   input  logic [AWIDTH-1:0] acc,
   input  logic [PWIDTH-1:0] prod,
   output logic [AWIDTH-1:0] sum
);

   logic [AWIDTH-1:0] prod_sx;

   assign prod_sx = {{(AWIDTH - PWIDTH){prod[PWIDTH-1]}}, prod};
   assign sum     = acc + prod_sx;

endmodule

// File: rtl/prod_accum.sv
// Accumulates signed multiplier products into blocks of up to NTERMS terms
// and presents each block sum on a valid/ready output port.
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NTERMS = DEF_NTERMS
) (
   input logic         clk,
   input logic         rst,
   prod_accum_if.slave bus
);

   localparam int PWIDTH = 2 * WIDTH;
   localparam int AWIDTH = PWIDTH + $clog2(NTERMS);
   localparam int CWIDTH = $clog2(NTERMS + 1);
   localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(NTERMS - 1);

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] acc_q, acc_d;
   logic [CWIDTH-1:0] cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [AWIDTH-1:0] out_sum_q, out_sum_d;
   logic [CWIDTH-1:0] out_terms_q, out_terms_d;

   logic [AWIDTH-1:0] sum;
   logic              in_accept;

   prod_accum_sext_adder #(
      .PWIDTH(PWIDTH),
      .AWIDTH(AWIDTH)
   ) u_sext_adder (
      .acc (acc_q),
      .prod(bus.in_prod),
      .sum (sum)
   );

   // A held sum blocks new products unless it is being drained this very cycle.
   assign bus.in_ready  = !rst && (state_q == ACCUM || bus.out_ready);
   assign in_accept     = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_terms = out_terms_q;

   // Next-state logic: drain a held sum, then apply the accumulate/close rules.
   // acc_q and cnt_q are already zero in HOLD, so a product accepted while
   // draining naturally starts the next block.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_terms_d = out_terms_q;

      if (state_q == HOLD && bus.out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ACCUM;
      end

      if (in_accept) begin
         if (cnt_q == LAST_CNT || bus.in_last) begin
            out_sum_d   = sum;
            out_terms_d = cnt_q + CWIDTH'(1);
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CWIDTH'(1);
         end
      end
   end

   // State register with synchronous reset that discards any partial or held sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_terms_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_terms_q <= out_terms_d;
      end
   end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream stage of the signed WIDTH x WIDTH array multiplier.
- Consumes the 2*WIDTH-bit two's-complement product stream over a valid/ready handshake.
- Sign-extends and sums up to NTERMS products per block, then presents the block sum on an output valid/ready port.
- Forms the accumulate half of the dot-product/MAC datapath.

Parameters:
- WIDTH, 6, multiplier operand width.
- NTERMS, 8, maximum products per block (>=2).
- PWIDTH, 2*WIDTH, product width (derived; not to be overridden).
- AWIDTH, PWIDTH+$clog2(NTERMS), accumulator/sum width; sized so that overflow cannot occur.
- CWIDTH, $clog2(NTERMS+1), term-count width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product present.
- in_ready  out  1  stage can accept a product.
- in_prod  in  PWIDTH  signed product (multiplier output z).
- in_last  in  1  this product closes the block early.
- out_valid  out  1  block sum available.
- out_ready  in  1  consumer accepts the sum.
- out_sum  out  AWIDTH  signed block sum.
- out_terms  out  CWIDTH  number of products in the sum (1..NTERMS).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state <= ACCUM; acc <= 0; cnt <= 0.
  - out_valid <= 0; out_sum <= 0; out_terms <= 0.
  - in_ready = 0 while rst is high.
  - Reset mid-block discards partial sums and any held output, with no output handshake.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output accept = out_valid & out_ready.
  - in_ready is combinational: !rst & (state==ACCUM | out_ready).
  - Upstream must hold in_prod and in_last stable while in_valid & !in_ready.
- sx = in_prod sign-extended to AWIDTH.
- State ACCUM (out_valid=0):
  - On accept with cnt<NTERMS-1 and in_last=0: acc <= acc+sx; cnt <= cnt+1.
  - On accept with cnt==NTERMS-1 or in_last=1:
    - out_sum <= acc+sx; out_terms <= cnt+1; out_valid <= 1.
    - acc <= 0; cnt <= 0; go to HOLD.
  - No accept: hold all state.
- State HOLD (out_valid=1):
  - out_sum and out_terms are stable until output accept.
  - out_ready=0: in_ready=0; input is ignored.
  - out_ready=1 and no input accept: out_valid <= 0; go to ACCUM.
  - out_ready=1 and input accept in the same cycle: the product starts the next block, i.e. the ACCUM accept rules apply from acc=0, cnt=0.
    - If that product also closes the block (in_last=1), out_sum/out_terms reload and out_valid stays 1 (back-to-back single-term blocks).
- Latency and throughput:
  - The sum is visible one cycle after the closing product is accepted.
  - Sustained throughput is one product per cycle when out_ready=1; there are no bubbles between blocks.
- Arithmetic:
  - Full-precision two's-complement, no saturation.
  - WIDTH=6, NTERMS=8: range -7936..+8192 fits in AWIDTH=15.
- in_last on the NTERMS-th product is redundant and harmless.

Decomposition:
- Shared package mult_pkg:
  - state enum {ACCUM, HOLD}.
  - sign-extend function sext(PWIDTH->AWIDTH).
  - Default WIDTH and NTERMS constants shared with the multiplier.
- No sub-module is required. An optional leaf sext_adder (sign-extend plus add) is acceptable if the team reuses it in the MAC.

Test Plan:
- Full block: after reset, 8 products of 12'h0D2 (-10 x -21 = 210), out_ready=1 -> out_valid one cycle after the 8th accept, out_sum=1680, out_terms=8.
- Extremes:
  - 8 x (+1024, 12'h400) -> out_sum=15'h2000 (8192).
  - 8 x (-992, 12'hC20) -> out_sum=-7936 (15'h6100).
- Early close: 210, -50, 7 with in_last on the 3rd -> out_sum=167, out_terms=3; the next block starts from 0.
- Backpressure:
  - Block closes, then out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_sum/out_terms stable for those 5 cycles; no product consumed.
  - Then out_ready=1 with in_valid=1, in_prod=5 -> the sum drains and 5 becomes term 1 of the next block.
- Back-to-back: in_last=1 on every product (3, -4, 9), out_ready=1 -> out_valid held high for 3 consecutive cycles with out_sum 3, -4, 9 and out_terms=1.
- Reset mid-block: 4 x 100 accepted, then rst=1 for 1 cycle, then 8 x 1 -> no output for the first 4; second block out_sum=8.
